// File: rtl/ceres_param.sv
// Shared memory-subsystem parameters and types for the line arbiter.
package ceres_param;

    localparam int BLK_SIZE      = 128;
    localparam int MEM_ARB_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } mem_arb_state_e;

    // Saturating increment for 32-bit event counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            sat_inc32 = value;
        end else begin
            sat_inc32 = value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/mem_line_arbiter_rr.sv
// Two-requester round-robin arbiter; the pointer moves to the losing port on adv.
module rr_arbiter2
    import ceres_param::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [MEM_ARB_PORTS-1:0] req,
    input  logic                     adv,
    output logic [MEM_ARB_PORTS-1:0] gnt
);

    logic ptr_r;

    // Sole requester wins; a conflict is resolved by the pointer.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_r ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer register: winner 0 hands priority to port 1 and vice versa.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_r <= 1'b0;
        end else if (adv) begin
            ptr_r <= gnt[0];
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/mem_line_arbiter.sv
// Shares the line-wide RAM port between D-cache (port 0) and I-cache (port 1).
// Optional counters are built when MEM_ARB_PERF_EN is defined.
module mem_line_arbiter
    import ceres_param::*;
#(
    parameter int LINE_W     = BLK_SIZE,
    parameter int ADDR_W     = 15,
    parameter int RD_LATENCY = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [MEM_ARB_PORTS-1:0]        req_valid_i,
    output logic [MEM_ARB_PORTS-1:0]        req_ready_o,
    input  logic [MEM_ARB_PORTS-1:0]        req_we_i,
    input  logic [2*ADDR_W-1:0]             req_addr_i,
    input  logic [2*LINE_W-1:0]             req_wdata_i,
    input  logic [2*(LINE_W/8)-1:0]         req_wstrb_i,
    output logic [MEM_ARB_PORTS-1:0]        rsp_valid_o,
    input  logic [MEM_ARB_PORTS-1:0]        rsp_ready_i,
    output logic [LINE_W-1:0]               rsp_rdata_o,
    input  logic                            mem_lock_i,
    output logic [ADDR_W-1:0]               ram_addr_o,
    output logic [LINE_W-1:0]               ram_wdata_o,
    output logic [LINE_W/8-1:0]             ram_wstrb_o,
    output logic                            ram_rd_en_o,
    input  logic [LINE_W-1:0]               ram_rdata_i,
    output logic                            busy_o
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]                     perf_grant0_o,
    output logic [31:0]                     perf_grant1_o,
    output logic [31:0]                     perf_conflict_o
`endif
);

    localparam int         STRB_W   = LINE_W / 8;
    localparam logic [1:0] LAT_LOAD = 2'(RD_LATENCY - 1);

    mem_arb_state_e     state_r, state_s;
    logic [1:0]         lat_cnt_r, lat_cnt_s;
    logic               port_r, port_s;
    logic               cap_s;
    logic [LINE_W-1:0]  rdata_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [LINE_W-1:0]  wdata_r;

    logic [1:0]         req_s, gnt_s;
    logic               grant_s, gsel_s, sel_we_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [LINE_W-1:0]  sel_wdata_s;
    logic [STRB_W-1:0]  sel_wstrb_s;

    // Requests are only eligible in IDLE, unlocked, and out of reset so no
    // grant can leak onto the outputs while rst_ni is low.
    assign req_s = (state_r == IDLE && !mem_lock_i && rst_ni) ? req_valid_i : 2'b00;

    rr_arbiter2 u_rr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req    (req_s),
        .adv    (grant_s),
        .gnt    (gnt_s)
    );

    assign grant_s     = |gnt_s;
    assign gsel_s      = gnt_s[1];
    assign sel_we_s    = gsel_s ? req_we_i[1] : req_we_i[0];
    assign sel_addr_s  = gsel_s ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
    assign sel_wdata_s = gsel_s ? req_wdata_i[2*LINE_W-1:LINE_W] : req_wdata_i[LINE_W-1:0];
    assign sel_wstrb_s = gsel_s ? req_wstrb_i[2*STRB_W-1:STRB_W] : req_wstrb_i[STRB_W-1:0];

    // Next-state logic: grant, read-latency countdown, response handshake.
    always_comb begin
        state_s   = state_r;
        lat_cnt_s = lat_cnt_r;
        port_s    = port_r;
        cap_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    port_s = gsel_s;
                    if (sel_we_s) begin
                        state_s = RESP;
                    end else begin
                        state_s   = RD_WAIT;
                        lat_cnt_s = LAT_LOAD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD_WAIT: begin
                if (lat_cnt_r == 2'd0) begin
                    cap_s   = 1'b1;
                    state_s = RESP;
                end else begin
                    lat_cnt_s = lat_cnt_r - 2'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i[port_r]) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // RAM side is driven straight from the winner; address/data hold otherwise.
    always_comb begin
        req_ready_o = gnt_s;
        if (grant_s) begin
            ram_addr_o  = sel_addr_s;
            ram_wdata_o = sel_wdata_s;
            ram_wstrb_o = sel_we_s ? sel_wstrb_s : {STRB_W{1'b0}};
            ram_rd_en_o = !sel_we_s;
        end else begin
            ram_addr_o  = addr_r;
            ram_wdata_o = wdata_r;
            ram_wstrb_o = {STRB_W{1'b0}};
            ram_rd_en_o = 1'b0;
        end
    end

    // Response side decodes from the FSM state and the latched port.
    always_comb begin
        if (state_r == RESP) begin
            rsp_valid_o = port_r ? 2'b10 : 2'b01;
        end else begin
            rsp_valid_o = 2'b00;
        end
        rsp_rdata_o = rdata_r;
        busy_o      = (state_r != IDLE);
    end

    // State, counter, port, read line and held RAM address/data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            lat_cnt_r <= 2'd0;
            port_r    <= 1'b0;
            rdata_r   <= {LINE_W{1'b0}};
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= {LINE_W{1'b0}};
        end else begin
            state_r   <= state_s;
            lat_cnt_r <= lat_cnt_s;
            port_r    <= port_s;
            rdata_r   <= cap_s ? ram_rdata_i : rdata_r;
            addr_r    <= grant_s ? sel_addr_s : addr_r;
            wdata_r   <= grant_s ? sel_wdata_s : wdata_r;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_g0_r, perf_g1_r, perf_cf_r;
    logic        conflict_s;

    assign conflict_s = (state_r == IDLE) && (req_valid_i == 2'b11) && !mem_lock_i;

    // Grant and conflict counters saturate instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_g0_r <= 32'd0;
            perf_g1_r <= 32'd0;
            perf_cf_r <= 32'd0;
        end else begin
            perf_g0_r <= gnt_s[0] ? sat_inc32(perf_g0_r) : perf_g0_r;
            perf_g1_r <= gnt_s[1] ? sat_inc32(perf_g1_r) : perf_g1_r;
            perf_cf_r <= conflict_s ? sat_inc32(perf_cf_r) : perf_cf_r;
        end
    end

    assign perf_grant0_o   = perf_g0_r;
    assign perf_grant1_o   = perf_g1_r;
    assign perf_conflict_o = perf_cf_r;
`endif

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Self-checking bench for mem_line_arbiter: directed scenarios plus random traffic
// compared against a transaction-level model (shadow memory, grant order, latencies).
module tb_mem_line_arbiter;

    localparam int LW     = 128;
    localparam int AW     = 15;
    localparam int SW     = LW / 8;
    localparam int RD_LAT = 1;
    localparam int NOLOCK = 100000;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [1:0]      req_valid_i, req_ready_o, req_we_i, rsp_valid_o, rsp_ready_i;
    logic [2*AW-1:0] req_addr_i;
    logic [2*LW-1:0] req_wdata_i;
    logic [2*SW-1:0] req_wstrb_i;
    logic [LW-1:0]   rsp_rdata_o, ram_wdata_o, ram_rdata_i;
    logic            mem_lock_i, ram_rd_en_o, busy_o;
    logic [AW-1:0]   ram_addr_o;
    logic [SW-1:0]   ram_wstrb_o;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]     perf_grant0_o, perf_grant1_o, perf_conflict_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    mem_line_arbiter #(.LINE_W(LW), .ADDR_W(AW), .RD_LATENCY(RD_LAT)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_wstrb_i (req_wstrb_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .mem_lock_i  (mem_lock_i),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_wstrb_o (ram_wstrb_o),
        .ram_rd_en_o (ram_rd_en_o),
        .ram_rdata_i (ram_rdata_i),
        .busy_o      (busy_o)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_grant0_o   (perf_grant0_o),
        .perf_grant1_o   (perf_grant1_o),
        .perf_conflict_o (perf_conflict_o)
`endif
    );

    // RAM environment: byte-strobed write, one-cycle registered read, 256 lines.
    logic [LW-1:0] ram_mem [0:255];
    logic          clr_ram, pre_en;
    logic [7:0]    pre_idx;
    logic [LW-1:0] pre_val;

    always @(posedge clk_i) begin
        if (clr_ram) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
        end else if (pre_en) begin
            ram_mem[pre_idx] <= pre_val;
        end else begin
            for (int b = 0; b < SW; b++)
                if (ram_wstrb_o[b]) ram_mem[ram_addr_o[9:2]][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
            if (ram_rd_en_o) ram_rdata_i <= ram_mem[ram_addr_o[9:2]];
        end
    end

    // Reference model state
    logic [LW-1:0] ref_mem [0:255];
    logic          ptr_m;
    logic [LW-1:0] rdata_m, last_wdata;
    logic [AW-1:0] last_addr;
    int            grants_m [2];
    int            conflict_m;

    bit            pend [2];
    bit            p_we [2];
    logic [AW-1:0] p_addr [2];
    logic [LW-1:0] p_wdata [2];
    logic [SW-1:0] p_wstrb [2];
    int            hold_req [2];
    int            start_c [2];

    function automatic logic [LW-1:0] merge(input logic [LW-1:0] old, input logic [LW-1:0] nw,
                                            input logic [SW-1:0] st);
        merge = old;
        for (int b = 0; b < SW; b++) if (st[b]) merge[b*8 +: 8] = nw[b*8 +: 8];
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input bit we, input logic [AW-1:0] a, input logic [LW-1:0] d,
                           input logic [SW-1:0] s, input int hold, input int st);
        pend[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wdata[p] = d;
        p_wstrb[p] = s; hold_req[p] = hold; start_c[p] = st;
    endtask

    task automatic rand_req(input int p);
        set_req(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 1023)),
                {$urandom, $urandom, $urandom, $urandom}, SW'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 2));
    endtask

    task automatic preload(input int idx, input logic [LW-1:0] val);
        pre_en = 1'b1; pre_idx = 8'(idx); pre_val = val;
        @(posedge clk_i); #1;
        pre_en = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Drives the pending requests cycle by cycle and checks every DUT output
    // against the model until all requests have been answered.
    task automatic run_engine(input int lock_on, input int lock_off);
        int cyc = 0; bit inflight = 0; bit done = 0; int cur = 0; bit cur_we = 0;
        int rsp_at = 0; int hold = 0; int w = 0; bit lk;
        logic [LW-1:0] cur_line = '0;
        logic [1:0] vis, exp_rdy, exp_rv;
        while (!done && cyc < 200) begin
            @(posedge clk_i); #1;
            for (int p = 0; p < 2; p++) begin
                vis[p] = pend[p] && (cyc >= start_c[p]);
                req_we_i[p] = p_we[p];
                req_addr_i[p*AW +: AW] = p_addr[p];
                req_wdata_i[p*LW +: LW] = p_wdata[p];
                req_wstrb_i[p*SW +: SW] = p_wstrb[p];
            end
            req_valid_i = vis;
            lk = (cyc >= lock_on) && (cyc < lock_off);
            mem_lock_i = lk;
            if (inflight && !cur_we && cyc == rsp_at) rdata_m = cur_line;
            #1;
            exp_rdy = 2'b00;
            if (!inflight && vis != 2'b00 && !lk) begin
                w = (vis == 2'b11) ? int'(ptr_m) : (vis[1] ? 1 : 0);
                exp_rdy[w] = 1'b1;
                if (vis == 2'b11) conflict_m++;
            end
            chk("req_ready", LW'(req_ready_o), LW'(exp_rdy));
            if (exp_rdy != 2'b00) begin
                chk("grant_rd_en", LW'(ram_rd_en_o), LW'(!p_we[w]));
                chk("grant_wstrb", LW'(ram_wstrb_o), p_we[w] ? LW'(p_wstrb[w]) : {LW{1'b0}});
                chk("grant_addr", LW'(ram_addr_o), LW'(p_addr[w]));
                chk("grant_wdata", ram_wdata_o, p_wdata[w]);
            end else begin
                chk("idle_rd_en", LW'(ram_rd_en_o), {LW{1'b0}});
                chk("idle_wstrb", LW'(ram_wstrb_o), {LW{1'b0}});
                chk("hold_addr", LW'(ram_addr_o), LW'(last_addr));
                chk("hold_wdata", ram_wdata_o, last_wdata);
            end
            exp_rv = 2'b00;
            if (inflight && cyc >= rsp_at) exp_rv[cur] = 1'b1;
            chk("rsp_valid", LW'(rsp_valid_o), LW'(exp_rv));
            chk("rsp_rdata", rsp_rdata_o, rdata_m);
            chk("busy", LW'(busy_o), LW'(inflight));

            rsp_ready_i = 2'($urandom);
            if (exp_rv != 2'b00) begin
                rsp_ready_i[cur] = (hold == 0);
                if (hold == 0) begin
                    inflight = 1'b0;
                    done = !(pend[0] || pend[1]);
                end else begin
                    hold--;
                end
            end
            if (exp_rdy != 2'b00) begin
                inflight = 1'b1; cur = w; cur_we = p_we[w]; hold = hold_req[w];
                rsp_at = cyc + (p_we[w] ? 1 : RD_LAT + 1);
                last_addr = p_addr[w]; last_wdata = p_wdata[w];
                grants_m[w]++;
                ptr_m = (w == 0);
                if (p_we[w]) ref_mem[p_addr[w][9:2]] = merge(ref_mem[p_addr[w][9:2]], p_wdata[w], p_wstrb[w]);
                else cur_line = ref_mem[p_addr[w][9:2]];
                pend[w] = 1'b0;
            end
            cyc++;
        end
        chk("engine_done", LW'(done), LW'(1'b1));
    endtask

    initial begin
        rst_ni = 1'b0; clr_ram = 1'b1; pre_en = 1'b0; pre_idx = 8'd0; pre_val = '0;
        req_valid_i = 2'b00; req_we_i = 2'b00; req_addr_i = '0; req_wdata_i = '0;
        req_wstrb_i = '0; rsp_ready_i = 2'b00; mem_lock_i = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        ptr_m = 1'b0; rdata_m = '0; last_addr = '0; last_wdata = '0;
        grants_m = '{0, 0}; conflict_m = 0;
        pend = '{0, 0};

        // Reset values
        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_req_ready", LW'(req_ready_o), {LW{1'b0}});
        chk("rst_rsp_valid", LW'(rsp_valid_o), {LW{1'b0}});
        chk("rst_rsp_rdata", rsp_rdata_o, {LW{1'b0}});
        chk("rst_ram_addr", LW'(ram_addr_o), {LW{1'b0}});
        chk("rst_ram_wdata", ram_wdata_o, {LW{1'b0}});
        chk("rst_ram_wstrb", LW'(ram_wstrb_o), {LW{1'b0}});
        chk("rst_ram_rd_en", LW'(ram_rd_en_o), {LW{1'b0}});
        chk("rst_busy", LW'(busy_o), {LW{1'b0}});
`ifdef MEM_ARB_PERF_EN
        chk("rst_perf_conflict", LW'(perf_conflict_o), {LW{1'b0}});
`endif
        rst_ni = 1'b1; clr_ram = 1'b0;
        @(posedge clk_i); #1;

        preload(4, {$urandom, $urandom, $urandom, 32'hDEAD_BEEF});
        preload(1, {$urandom, $urandom, $urandom, $urandom});
        preload(16, {$urandom, $urandom, $urandom, $urandom});
        preload(32, {$urandom, $urandom, $urandom, $urandom});

        // Simultaneous reads after reset: port 0 first, then port 1
        set_req(0, 1'b0, 15'h0040, '0, '0, 0, 0);
        set_req(1, 1'b0, 15'h0080, '0, '0, 0, 0);
        run_engine(NOLOCK, NOLOCK);

        // Lone port 0 read of the DEADBEEF line
        set_req(0, 1'b0, 15'h0010, '0, '0, 0, 0);
        run_engine(NOLOCK, NOLOCK);

        // Port 1 partial write, then a read of the merged line
        set_req(1, 1'b1, 15'h0004, {$urandom, $urandom, $urandom, 32'h1234_5678}, 16'h000F, 0, 0);
        run_engine(NOLOCK, NOLOCK);
        set_req(0, 1'b0, 15'h0004, '0, '0, 0, 0);
        run_engine(NOLOCK, NOLOCK);

        // Zero-strobe write still acknowledged
        set_req(0, 1'b1, 15'h0008, {$urandom, $urandom, $urandom, $urandom}, 16'h0000, 1, 0);
        run_engine(NOLOCK, NOLOCK);

        // Back-pressured response with the other port waiting
        set_req(0, 1'b0, 15'h0010, '0, '0, 5, 0);
        set_req(1, 1'b0, 15'h0040, '0, '0, 0, 1);
        run_engine(NOLOCK, NOLOCK);

        // Lock raised while a read is in flight, both ports valid
        set_req(0, 1'b0, 15'h0080, '0, '0, 0, 0);
        set_req(1, 1'b0, 15'h0004, '0, '0, 0, 0);
        run_engine(1, 7);

        // Random traffic with occasional lock windows
        for (int it = 0; it < 25; it++) begin
            int m, lon, loff;
            m = $urandom_range(1, 3);
            if (m[0]) rand_req(0);
            if (m[1]) rand_req(1);
            lon = NOLOCK; loff = NOLOCK;
            if ($urandom_range(0, 3) == 0) begin
                lon = $urandom_range(0, 3);
                loff = lon + $urandom_range(1, 5);
            end
            run_engine(lon, loff);
        end

        // Reset pulse while a read waits for RAM data
        @(posedge clk_i); #1;
        mem_lock_i = 1'b0;
        req_we_i = 2'b00; req_addr_i[AW-1:0] = 15'h0020; req_valid_i = 2'b01;
        #1;
        chk("pre_rst_grant", LW'(req_ready_o), LW'(2'b01));
        @(posedge clk_i); #1;
        req_valid_i = 2'b00;
        chk("pre_rst_busy", LW'(busy_o), LW'(1'b1));
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_req_ready", LW'(req_ready_o), {LW{1'b0}});
        chk("mid_rst_rsp_valid", LW'(rsp_valid_o), {LW{1'b0}});
        chk("mid_rst_rsp_rdata", rsp_rdata_o, {LW{1'b0}});
        chk("mid_rst_ram_addr", LW'(ram_addr_o), {LW{1'b0}});
        chk("mid_rst_ram_wdata", ram_wdata_o, {LW{1'b0}});
        chk("mid_rst_ram_wstrb", LW'(ram_wstrb_o), {LW{1'b0}});
        chk("mid_rst_ram_rd_en", LW'(ram_rd_en_o), {LW{1'b0}});
        chk("mid_rst_busy", LW'(busy_o), {LW{1'b0}});
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        ptr_m = 1'b0; rdata_m = '0; last_addr = '0; last_wdata = '0;
        grants_m = '{0, 0}; conflict_m = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #2;
            chk("post_rst_rsp_valid", LW'(rsp_valid_o), {LW{1'b0}});
            chk("post_rst_busy", LW'(busy_o), {LW{1'b0}});
        end

        // Contested traffic for the conflict counter
        for (int it = 0; it < 10; it++) begin
            rand_req(0);
            rand_req(1);
            start_c[0] = 0; start_c[1] = 0;
            run_engine(NOLOCK, NOLOCK);
        end
`ifdef MEM_ARB_PERF_EN
        chk("perf_grant0", LW'(perf_grant0_o), LW'(grants_m[0]));
        chk("perf_grant1", LW'(perf_grant1_o), LW'(grants_m[1]));
        chk("perf_conflict", LW'(perf_conflict_o), LW'(conflict_m));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
Two-port arbiter and sequencer in front of the cache-line-wide main memory (LINE_W data, byte strobes, registered read with RD_LATENCY). It shares the single RAM port between the D-cache refill/writeback path (port 0) and the I-cache refill path (port 1) using round-robin arbitration. It issues one transaction at a time and returns read data or a write acknowledge through a valid/ready response channel per port. It also freezes new grants while the UART programmer owns the memory.

Parameters:
LINE_W, ceres_param::BLK_SIZE (128), cache line width in bits; must be a multiple of 32
ADDR_W, 15, word (32-bit) address width driven to the RAM
RD_LATENCY, 1, cycles from rd_en_o to valid ram_rdata_i; range 1..4

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  2  per-port request valid; bit 0 = D-cache, bit 1 = I-cache
req_ready_o  out  2  per-port request accept; one-hot or zero
req_we_i  in  2  per-port write flag
req_addr_i  in  2*ADDR_W  per-port word address, packed by port
req_wdata_i  in  2*LINE_W  per-port write line
req_wstrb_i  in  2*LINE_W/8  per-port byte strobes
rsp_valid_o  out  2  per-port response valid
rsp_ready_i  in  2  per-port response ready
rsp_rdata_o  out  LINE_W  read line; valid when either rsp_valid_o bit is 1
mem_lock_i  in  1  programmer active (prog_mode); blocks new grants
ram_addr_o  out  ADDR_W  RAM word address
ram_wdata_o  out  LINE_W  RAM write data
ram_wstrb_o  out  LINE_W/8  RAM byte strobes
ram_rd_en_o  out  1  RAM read enable
ram_rdata_i  in  LINE_W  RAM read data
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; round-robin pointer at port 0; latency counter 0; the registered rdata is 0.
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE grant condition: at least one req_valid_i bit set and mem_lock_i = 0.
- Arbitration:
  - If only one port is valid, that port wins.
  - If both are valid, the port named by the pointer wins.
  - After each grant, the pointer moves to the other port.
- Grant cycle:
  - req_ready_o[p] = 1 for exactly that cycle, combinationally.
  - RAM outputs are driven combinationally from port p in the same cycle.
- Write grant:
  - ram_wstrb_o = req_wstrb_i[p]; ram_rd_en_o = 0.
  - Next state is RESP; rsp_rdata_o is unchanged.
  - A write with all-zero wstrb is still granted and acknowledged.
- Read grant:
  - ram_rd_en_o = 1 and ram_wstrb_o = 0; next state is RD_WAIT with the counter loaded to RD_LATENCY-1.
  - In RD_WAIT, the counter decrements each cycle.
  - When the counter reaches 0, ram_rdata_i is captured into the rsp_rdata_o register and the FSM moves to RESP.
- RESP:
  - rsp_valid_o[p] = 1 until rsp_ready_i[p] = 1; then return to IDLE.
  - No grant happens in the same cycle as the response handshake.
- Latency:
  - Read: grant at cycle T, rsp_valid_o rises at T+RD_LATENCY+1.
  - Write: grant at T, rsp_valid_o rises at T+1.
  - Minimum transaction spacing is 2 cycles for writes and RD_LATENCY+2 cycles for reads.
- Outside a grant cycle: ram_wstrb_o = 0, ram_rd_en_o = 0, and ram_addr_o/ram_wdata_o hold their last values (no toggling).
- Requesters must hold address, data and we stable while valid and not ready; the arbiter samples only in the grant cycle.
- mem_lock_i asserted mid-transaction: the in-flight transaction completes normally, and no new grant occurs while the lock is high.
- Reset asserted mid-transaction: the transaction is dropped with no response, and all outputs return to reset values asynchronously.
- rsp_ready_i on a port with no pending response is ignored.
- Address bits [1:0] are forwarded unchanged; the RAM ignores them for line selection.

Optional Feature:
MEM_ARB_PERF_EN
- Defined: adds 32-bit saturating counters and outputs perf_grant0_o, perf_grant1_o and perf_conflict_o. The conflict counter increments in every IDLE cycle where both ports are valid and unlocked. The counters reset to 0 and have no clear input.
- Undefined: the ports and logic are absent.

Decomposition:
- ceres_param gains typedef mem_arb_state_e (IDLE, RD_WAIT, RESP) and the constant MEM_ARB_PORTS = 2.
- One sub-module, rr_arbiter2: a two-requester round-robin grant with pointer update on an advance strobe.
- The FSM, latency counter and response register stay in mem_line_arbiter.

Test Plan:
1. Port 0 read addr 0x0010 alone, RAM model returns 0x...DEADBEEF at RD_LATENCY=1 -> ram_rd_en_o high for 1 cycle with addr 0x0010; rsp_valid_o[0] at T+2 with that data; req_ready_o[1] stays 0.
2. Both ports request reads in the same cycle after reset -> port 0 granted first, then port 1; the pointer ends at port 0; both responses carry the correct lines.
3. Port 1 write wstrb 0x000F, data 0x1234_5678 at addr 0x0004 -> ram_wstrb_o = 0x000F for exactly 1 cycle; rsp_valid_o[1] at T+1; a subsequent read returns the merged line.
4. Hold rsp_ready_i[0]=0 for 5 cycles during a pending response while port 1 is valid -> rsp_valid_o[0] and rsp_rdata_o remain stable; port 1 is not granted until 1 cycle after the response handshake.
5. Assert mem_lock_i during RD_WAIT with both ports valid -> the read completes and is responded; no grant occurs until mem_lock_i falls, and the first grant is 1 cycle after it drops.
6. Pulse rst_ni low in RD_WAIT -> all outputs 0 immediately and no stale response; then, with MEM_ARB_PERF_EN defined, 10 contested cycles -> perf_conflict_o counts the IDLE cycles in which both ports were valid.
